// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the glitch-free integer clock divider.
package clk_div_pkg;

   // Smallest ratio that actually divides; 0 and 1 select bypass.
   localparam int unsigned MIN_DIV_RATIO = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } div_state_e;

   // Phase lengths are computed at 32 bits so one definition serves any
   // divider WIDTH up to 31; callers truncate to their own counter width.
   function automatic int unsigned hi_len(input int unsigned r);
      return r - (r >> 1);
   endfunction

   function automatic int unsigned lo_len(input int unsigned r);
      return r >> 1;
   endfunction

endpackage

// File: rtl/clk_div_glitchfree.sv
// Integer clock divider with boundary-aligned ratio/enable changes and a
// reference-clock bypass. Odd ratios put the extra cycle in the high phase.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | bypass: output follows i_ref_clk, waiting for enable and ratio > 1
// HIGH  | divided clock high, cnt counts down the remaining high cycles
// LOW   | divided clock low, cnt == 0 here is the period end / reload point
module clk_div_glitchfree
   import clk_div_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             i_ref_clk,
   input  logic             i_rst_n,
   input  logic             i_clk_en,
   input  logic [WIDTH-1:0] i_div_ratio,
   output logic             o_div_clk,
   output logic             o_div_tick,
   output logic             o_locked,
   output logic             o_ratio_upd,
   output logic [WIDTH-1:0] o_ratio_act
);

   div_state_e       state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             div_q, div_d;
   logic [WIDTH-1:0] r_act_q, r_act_d;
   logic             tick_q, tick_d;
   logic             upd_q, upd_d;

   logic             go;
   logic [WIDTH-1:0] hi_cnt_new;
   logic [WIDTH-1:0] lo_cnt_act;

   assign go         = i_clk_en && (32'(i_div_ratio) >= MIN_DIV_RATIO);
   // Load values are length-1 so the terminal count (cnt == 0) is the last
   // cycle of each phase; the largest ratio needs 2^(WIDTH-1)-1, which fits.
   assign hi_cnt_new = WIDTH'(hi_len(32'(i_div_ratio)) - 32'd1);
   assign lo_cnt_act = WIDTH'(lo_len(32'(r_act_q)) - 32'd1);

   // State, counter and registered pulse outputs.
   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         div_q   <= 1'b0;
         r_act_q <= '0;
         tick_q  <= 1'b0;
         upd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         r_act_q <= r_act_d;
         tick_q  <= tick_d;
         upd_q   <= upd_d;
      end
   end

   // Next-state logic; inputs are only looked at in IDLE and at the period end.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      r_act_d = r_act_q;
      tick_d  = 1'b0;
      upd_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (go) begin
               state_d = HIGH;
               div_d   = 1'b1;
               cnt_d   = hi_cnt_new;
               r_act_d = i_div_ratio;
               tick_d  = 1'b1;
            end
         end
         HIGH: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - WIDTH'(1);
            end else begin
               state_d = LOW;
               div_d   = 1'b0;
               cnt_d   = lo_cnt_act;
            end
         end
         LOW: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - WIDTH'(1);
            end else if (go) begin
               // Disable takes priority: a ratio change only counts if we keep dividing.
               state_d = HIGH;
               div_d   = 1'b1;
               cnt_d   = hi_cnt_new;
               r_act_d = i_div_ratio;
               tick_d  = 1'b1;
               upd_d   = (i_div_ratio != r_act_q);
            end else begin
               state_d = IDLE;
               div_d   = 1'b0;
               r_act_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            div_d   = 1'b0;
            cnt_d   = '0;
            r_act_d = '0;
         end
      endcase
   end

   // Single output clock mux. Mode switches happen on a ref rising edge, where
   // i_ref_clk and div agree on the side that matters (both 1 entering HIGH,
   // and leaving LOW the ref rise lands exactly where the next period would
   // begin), so no runt edge is produced.
   assign o_div_clk   = (state_q == IDLE) ? i_ref_clk : div_q;
   assign o_locked    = (state_q != IDLE);
   assign o_div_tick  = tick_q;
   assign o_ratio_upd = upd_q;
   assign o_ratio_act = r_act_q;

endmodule

// File: tb/tb_clk_div_glitchfree.sv
// Bench for clk_div_glitchfree: directed scenarios plus random ratio/enable
// traffic, checked against a period-position reference model.
module tb_clk_div_glitchfree;

   localparam int WIDTH = 8;

   logic             i_ref_clk = 1'b0;
   logic             i_rst_n;
   logic             i_clk_en;
   logic [WIDTH-1:0] i_div_ratio;
   logic             o_div_clk;
   logic             o_div_tick;
   logic             o_locked;
   logic             o_ratio_upd;
   logic [WIDTH-1:0] o_ratio_act;

   clk_div_glitchfree #(.WIDTH(WIDTH)) dut (
      .i_ref_clk   (i_ref_clk),
      .i_rst_n     (i_rst_n),
      .i_clk_en    (i_clk_en),
      .i_div_ratio (i_div_ratio),
      .o_div_clk   (o_div_clk),
      .o_div_tick  (o_div_tick),
      .o_locked    (o_locked),
      .o_ratio_upd (o_ratio_upd),
      .o_ratio_act (o_ratio_act)
   );

   always #5 i_ref_clk = ~i_ref_clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: dividing flag, ratio in effect, position within period.
   bit m_div;
   int m_r;
   int m_pos;
   bit m_tick;
   bit m_upd;

   task automatic model_reset();
      m_div = 0; m_r = 0; m_pos = 0; m_tick = 0; m_upd = 0;
   endtask

   task automatic model_edge();
      bit go;
      go = i_clk_en && (int'(i_div_ratio) > 1);
      m_tick = 0;
      m_upd  = 0;
      if (!m_div) begin
         if (go) begin
            m_div = 1; m_r = int'(i_div_ratio); m_pos = 0; m_tick = 1;
         end
      end else begin
         m_pos++;
         if (m_pos == m_r) begin
            if (go) begin
               m_upd  = (int'(i_div_ratio) != m_r);
               m_r    = int'(i_div_ratio);
               m_pos  = 0;
               m_tick = 1;
            end else begin
               m_div = 0; m_r = 0; m_pos = 0;
            end
         end
      end
   endtask

   function automatic logic exp_clk(input logic ref_lvl);
      if (m_div) return (m_pos < (m_r + 1) / 2);
      return ref_lvl;
   endfunction

   // One ref cycle: update model at the edge, check with ref high and ref low.
   task automatic step();
      @(posedge i_ref_clk);
      if (i_rst_n) model_edge();
      #2;
      check_eq("div_clk_hi", o_div_clk, exp_clk(1'b1));
      check_eq("div_tick", o_div_tick, m_tick);
      check_eq("locked", o_locked, m_div);
      check_eq("ratio_upd", o_ratio_upd, m_upd);
      check_eq("ratio_act", o_ratio_act, m_r);
      @(negedge i_ref_clk);
      #1;
      check_eq("div_clk_lo", o_div_clk, exp_clk(1'b0));
   endtask

   task automatic wait_pos(input int r, input int pos, input string tag);
      bit found;
      found = 0;
      for (int i = 0; i < 600; i++) begin
         if (m_div && m_r == r && m_pos == pos) begin
            found = 1;
            break;
         end
         step();
      end
      check_eq(tag, found, 1);
   endtask

   // Runt detector: any output level shorter than a ref half-period.
   time last_t  = 0;
   bit  last_ok = 0;
   int  runts   = 0;
   always @(o_div_clk or negedge i_rst_n) begin
      if (i_rst_n && last_ok && ($time - last_t < 5)) runts++;
      last_t  = $time;
      last_ok = i_rst_n;
   end

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_clk"}, o_div_clk, i_ref_clk);
      check_eq({tag, "_tick"}, o_div_tick, 0);
      check_eq({tag, "_locked"}, o_locked, 0);
      check_eq({tag, "_upd"}, o_ratio_upd, 0);
      check_eq({tag, "_act"}, o_ratio_act, 0);
   endtask

   int upd_cnt;
   int tick_cnt;

   initial begin
      i_rst_n     = 1'b0;
      i_clk_en    = 1'b1;
      i_div_ratio = 8'd4;
      model_reset();
      #13;
      check_reset_outputs("rst");
      @(negedge i_ref_clk);
      #1;
      i_rst_n = 1'b1;

      // Divide by 4, then 5, 2, 3 and the maximum ratio.
      repeat (20) step();
      tick_cnt = 0;
      repeat (40) begin
         step();
         if (o_div_tick) tick_cnt++;
      end
      check_eq("ticks_div4", tick_cnt, 10);
      i_div_ratio = 8'd5;  repeat (25) step();
      i_div_ratio = 8'd2;  repeat (12) step();
      i_div_ratio = 8'd3;  repeat (15) step();
      i_div_ratio = 8'd255; repeat (600) step();

      // Ratio change mid-HIGH, then rewrite of the same ratio.
      i_div_ratio = 8'd4;
      wait_pos(4, 0, "wait_r4");
      i_div_ratio = 8'd7;
      upd_cnt = 0;
      repeat (20) begin
         step();
         if (o_ratio_upd) upd_cnt++;
      end
      check_eq("upd_once", upd_cnt, 1);
      i_div_ratio = 8'd7;
      upd_cnt = 0;
      repeat (20) begin
         step();
         if (o_ratio_upd) upd_cnt++;
      end
      check_eq("upd_none", upd_cnt, 0);

      // Enable dropped in the first LOW cycle of ratio 6.
      i_div_ratio = 8'd6;
      wait_pos(6, 3, "wait_r6");
      i_clk_en = 1'b0;
      repeat (10) step();

      // Ratio 1 and 0 keep bypass; ratio 2 starts dividing.
      i_clk_en = 1'b1;
      i_div_ratio = 8'd1; repeat (10) step();
      i_div_ratio = 8'd0; repeat (10) step();
      i_div_ratio = 8'd2; repeat (10) step();

      // Async reset in the middle of a ratio-9 high phase.
      i_div_ratio = 8'd9;
      wait_pos(9, 2, "wait_r9");
      #1;
      i_rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      #5;
      check_reset_outputs("rst_hold");
      model_reset();
      @(negedge i_ref_clk);
      #1;
      i_rst_n = 1'b1;
      repeat (40) step();

      // Random ratio and enable traffic.
      repeat (1500) begin
         if ($urandom_range(0, 9) == 0) begin
            if ($urandom_range(0, 9) == 0) i_div_ratio = WIDTH'($urandom_range(0, 1));
            else                           i_div_ratio = WIDTH'($urandom_range(2, 12));
         end
         if ($urandom_range(0, 19) == 0) i_clk_en = ($urandom_range(0, 3) != 0);
         step();
      end

      check_eq("runt_pulses", runts, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/clk_div_glitchfree.md
Name: clk_div_glitchfree

Overview:
Parametrised integer clock divider for the UART system's baud and oversampling clocks.
- Ratio changes and enable changes take effect only at a divided-period boundary, so the output never glitches or produces a runt pulse.
- Provides a period-start tick and status flags.
- Bypasses to the reference clock when disabled or when the ratio is 0 or 1.

Parameters:
WIDTH, 8, width of the division ratio; valid ratios 2 .. 2^WIDTH-1.

Ports:
i_ref_clk  input  1  reference clock; all state on its rising edge
i_rst_n  input  1  asynchronous active-low reset
i_clk_en  input  1  divider enable; sampled only at period boundaries while dividing
i_div_ratio  input  WIDTH  requested ratio; sampled only at period boundaries
o_div_clk  output  1  divided clock, or i_ref_clk in bypass
o_div_tick  output  1  one-ref-cycle pulse that coincides with each divided rising edge
o_locked  output  1  1 while in divide mode (HIGH or LOW state)
o_ratio_upd  output  1  one-cycle pulse when a new, different ratio is adopted at a boundary
o_ratio_act  output  WIDTH  ratio currently in effect; 0 in bypass

Behaviour:
- States: IDLE (bypass), HIGH, LOW. Internal registers: state, cnt[WIDTH-1:0], div, r_act[WIDTH-1:0].
- Phase lengths for ratio r:
  - hi_len = r - (r>>1), i.e. ceil(r/2).
  - lo_len = r>>1, i.e. floor(r/2).
  - Odd ratios therefore have the high phase one ref cycle longer. Examples: r=2 gives 1/1, r=3 gives 2/1, r=7 gives 4/3.
- Definition: go = i_clk_en && (i_div_ratio > 1).
- Reset (asynchronous, any time, including mid-period):
  - state=IDLE, cnt=0, div=0, r_act=0.
  - o_div_tick=0, o_locked=0, o_ratio_upd=0, o_ratio_act=0.
  - o_div_clk = i_ref_clk.
- IDLE:
  - o_div_clk = i_ref_clk (combinational mux).
  - If go: r_act<=i_div_ratio, div<=1, cnt<=hi_len(i_div_ratio)-1, state<=HIGH, o_div_tick<=1.
  - Otherwise stay in IDLE.
- HIGH:
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: div<=0, cnt<=lo_len(r_act)-1, state<=LOW.
  - Input changes are ignored.
- LOW:
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0 (period end):
    - If go: div<=1, state<=HIGH, o_div_tick<=1, r_act<=i_div_ratio, cnt<=hi_len(i_div_ratio)-1. Also o_ratio_upd<=1 if i_div_ratio != r_act.
    - Else: state<=IDLE, div<=0, r_act<=0.
- In HIGH and LOW: o_div_clk=div and o_locked=1.
- Glitch-free mux: both mode switches happen at a ref rising edge, when i_ref_clk is high.
  - IDLE to HIGH: div=1.
  - LOW to IDLE: the output rises exactly where the next period would have begun.
  - Neither switch creates an extra edge or a short pulse.
- Latency:
  - From go asserted in IDLE to the first divided rising edge: the next ref posedge.
  - A ratio change mid-period is applied at the next period end. Worst-case delay is one full old period.
- o_div_tick and o_ratio_upd are registered, last exactly one ref cycle, and are 0 in every other cycle.
- Simultaneous events at a period end:
  - Enable drop wins over a ratio change; the block goes to IDLE and o_ratio_upd stays 0.
  - Changing to ratio 0 or 1 behaves the same as disable.
- Maximum ratio 2^WIDTH-1 gives hi_len=2^(WIDTH-1); cnt must hold up to 2^(WIDTH-1)-1. No overflow.
- Divided-period accuracy: exactly r ref cycles per period. There is no drift or accumulated error across ratio reloads.

Decomposition:
- Shared package clk_div_pkg holds:
  - the state enum (IDLE, HIGH, LOW);
  - hi_len/lo_len functions, parameterised by WIDTH;
  - constant MIN_DIV_RATIO=2.
- No sub-module. Keep the single FSM, counter and output mux in one module, for a single clock-mux point at the top.

Test Plan:
1. Reset release with i_clk_en=1, ratio=4 → o_div_clk 2 high / 2 low repeating. o_div_tick on every 4th cycle. o_locked=1. o_ratio_act=4.
2. Ratio=5 → high 3, low 2. o_div_tick period 5. Also sweep 2, 3 and 255 (128 high / 127 low) with period checks.
3. Ratio change 4→7 written mid-HIGH → current period completes as 4. The next period is 4/3. o_ratio_upd pulses once at that boundary. Rewriting the same ratio gives no pulse.
4. i_clk_en dropped mid-LOW of ratio 6 → LOW completes (3 cycles), then bypass. o_div_clk follows i_ref_clk. o_locked=0. No output pulse shorter than one ref half-period.
5. Ratio=1 or 0 with enable=1 → bypass, o_locked=0, o_div_tick never asserts. Then ratio=2 → divide-by-2 starts at the next posedge.
6. Async reset asserted mid-HIGH of ratio 9 → outputs go to reset values immediately, without waiting for a clock. After release, a clean divide-by-9 resumes.
